wb_ram_pipe: RTL and testbench
==============================

# wb_ram_pipe

Pipelined, parametrised Wishbone B4 RAM built from `ram512x32` macro banks, the successor of the classic single-access SoC RAM wrapper. It accepts one request per cycle, returns responses in order with a configurable 1- or 2-cycle latency, flags out-of-range addresses with `wb_err_o`, and zero-fills the whole array after reset or on request. It sits on the SoC data bus as the main scratch and data memory.

## Interface
- `DEPTH`, default 1024: number of 32-bit words; any value from 1 up. `NR_BANKS = ceil(DEPTH/512)`.
- `OUT_REG`, default 0: 1 adds an output register stage, giving read/ack latency 2 instead of 1.
- `CLEAR_ON_RESET`, default 1: 1 starts a zero-fill automatically after reset is released.
- `clk_i` input 1: single clock; all logic is on the rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `wb_cyc_i` input 1: bus cycle.
- `wb_stb_i` input 1: strobe.
- `wb_we_i` input 1: write enable.
- `wb_sel_i` input 4: byte lane select.
- `wb_adr_i` input `AW = max(1, clog2(NR_BANKS*512))`: word address.
- `wb_dat_i` input 32: write data.
- `wb_dat_o` output 32: read data; 0 whenever `wb_ack_o` is low.
- `wb_ack_o` output 1: successful response.
- `wb_err_o` output 1: error response, raised for address >= `DEPTH`.
- `wb_stall_o` output 1: request not accepted this cycle.
- `clear_i` input 1: single-cycle request to zero-fill the array.
- `busy_o` output 1: high while draining or clearing.

## Operation
- Accept condition: `wb_cyc_i & wb_stb_i & ~wb_stall_o`. Only an accepted request touches a macro.
- Bank index is `adr[AW-1:9]`; macro address is `adr[8:0]`.
- An in-range write drives `wen_i` of the addressed bank only and passes `wb_sel_i` through as the byte mask.
- An in-range read enables the addressed bank. The bank index is registered alongside the request so the read mux uses the bank of the request, not the current address.
- Macro `cen_i` is active-low:
  - 0 on cycles with an accepted access to that bank, or during CLEAR (all banks);
  - 1 otherwise, including while `rst_i` is high.
- An out-of-range request, in either direction, does not access any macro. It returns `wb_err_o`, with `wb_dat_o = 0`.
- Response pipeline: valid and err bits, depth 1 + `OUT_REG`, in order. `wb_ack_o` and `wb_err_o` are never both high.
- Abort: while `wb_cyc_i` is low, all in-flight valid bits are cleared. No response is produced for them; writes already issued remain committed.
- State machine states: READY, DRAIN, CLEAR.
  - Reset entry: `rst_i` gives CLEAR if `CLEAR_ON_RESET = 1`, else READY.
  - READY to DRAIN: `clear_i` is high, or an accepted request and `clear_i` occur in the same cycle. That request is still accepted and answered.
  - DRAIN to CLEAR: the response pipeline is empty.
  - CLEAR: a 9-bit counter `c` counts 0..511. Each cycle every bank writes 0 at `c` with sel = 4'hF. At `c = 511` the state goes to READY and the counter resets to 0.
  - `clear_i` is ignored outside READY.
- `wb_stall_o = 1` in DRAIN and CLEAR and while `rst_i` is high; 0 in READY.
- `busy_o = 1` in DRAIN and CLEAR; 0 in READY.

## Timing
- Reset values (`rst_i` high, and the first cycle after):
  - `wb_ack_o = 0`, `wb_err_o = 0`, `wb_dat_o = 0`;
  - pipeline valid bits cleared, counter = 0;
  - `wb_stall_o = 1`;
  - `busy_o = 1` if `CLEAR_ON_RESET`, else 0.
- Request accepted at edge N:
  - ack or err is high in cycle N+1 when `OUT_REG = 0`, or N+2 when `OUT_REG = 1`;
  - read data is valid in the same cycle as the ack.
- Throughput is one request per cycle. Mixed read/write back-to-back and bank-to-bank switching have no bubbles.
- A read to an address written in the previous cycle returns the new data. The write commits at the edge before the read samples.
- Clear duration is exactly 512 cycles in CLEAR, independent of `DEPTH`. DRAIN takes 0..(1+`OUT_REG`) cycles.
- `rst_i` asserted mid-clear or mid-drain aborts the operation. The counter restarts from 0 on the next entry to CLEAR.
- Addresses `DEPTH..NR_BANKS*512-1` inside the last bank are also out-of-range and return err.

## Test plan
- Reset-clear: `DEPTH = 1024`, `CLEAR_ON_RESET = 1`, preload garbage, then release `rst_i`. Required: stall/busy high for exactly 512 cycles; afterwards reads of addr 0, 511, 512, 1023 return 0 with ack.
- Byte lanes: write 0xDEADBEEF to addr 5 with sel = F, then 0x00AA0000 with sel = 4'b0100, then read addr 5. Required: read returns 0xDEAABEEF at ack latency 1 (`OUT_REG = 0`) and 2 (`OUT_REG = 1`).
- Bank switching: back-to-back reads of addr 511, 512, 0, 1023 holding words 1, 2, 3, 4. Required: acks on 4 consecutive cycles with data 1, 2, 3, 4 in order and no stall.
- Range error: `DEPTH = 600`, write then read addr 700. Required: `wb_err_o` at ack latency with no ack and data 0. A following read of addr 599 returns its prior contents, with no macro write observed at 700.
- Runtime clear: `clear_i` pulsed together with an accepted read and `OUT_REG = 1`. Required: the read gets its ack, DRAIN lasts until the pipeline is empty, CLEAR lasts 512 cycles, then all memory reads 0.
- Abort and reset:
  - drop `wb_cyc_i` one cycle after issuing a read: no ack is produced;
  - assert `rst_i` at clear cycle 200: the clear restarts and takes a full 512 cycles after release.

Source files
------------

// File: rtl/wb_ram_pipe.sv
// Pipelined Wishbone B4 RAM assembled from 512x32 banks: one request per cycle,
// in-order ack/err with 1- or 2-cycle latency, and a full zero-fill on reset or request.

// 512x32 single-port bank: active-low cen_i, active-high wen_i, per-byte mask, registered read.
module ram512x32 (
  input  logic        clk_i,
  input  logic        cen_i,
  input  logic        wen_i,
  input  logic [3:0]  be_i,
  input  logic [8:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  logic [31:0] mem [512];

  always_ff @(posedge clk_i) begin
    if (!cen_i) begin
      if (wen_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end
endmodule

module wb_ram_pipe #(
  parameter  int DEPTH          = 1024,
  parameter  int OUT_REG        = 0,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int NR_BANKS       = (DEPTH + 511) / 512,
  localparam int AW             = ($clog2(NR_BANKS * 512) > 1) ? $clog2(NR_BANKS * 512) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_stall_o,
  input  logic          clear_i,
  output logic          busy_o
);
  localparam int BW = (NR_BANKS > 1) ? $clog2(NR_BANKS) : 1;

  typedef enum logic [1:0] {ST_READY, ST_DRAIN, ST_CLEAR} state_t;

  state_t        state_reg;
  logic [8:0]    clr_cnt_reg;
  logic          v1_reg, e1_reg, rd1_reg;
  logic [BW-1:0] bank1_reg;

  logic          accept, in_range, clearing, drain_done;
  logic [BW-1:0] req_bank;
  logic [31:0]   bank_rdata [NR_BANKS];
  logic [31:0]   sel_rdata;
  logic          out_v, out_e;
  logic [31:0]   out_dat;

  assign wb_stall_o = rst_i | (state_reg != ST_READY);
  assign busy_o     = rst_i ? (CLEAR_ON_RESET != 0) : (state_reg != ST_READY);
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign in_range   = (32'(wb_adr_i) < 32'(DEPTH));
  assign clearing   = (state_reg == ST_CLEAR) & ~rst_i;

  generate
    if (NR_BANKS > 1) begin : g_bidx
      assign req_bank = wb_adr_i[AW-1:9];
    end else begin : g_bidx_one
      assign req_bank = '0;
    end
  endgenerate

  // With the output register, the last response may still sit in stage 2 while CLEAR starts.
  assign drain_done = (OUT_REG != 0) ? ~v1_reg : 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_reg <= '0;
      v1_reg      <= 1'b0;
      e1_reg      <= 1'b0;
      rd1_reg     <= 1'b0;
      bank1_reg   <= '0;
    end else begin
      v1_reg    <= accept;
      e1_reg    <= accept & ~in_range;
      rd1_reg   <= accept & in_range & ~wb_we_i;
      bank1_reg <= req_bank;
      case (state_reg)
        ST_READY: if (clear_i) state_reg <= ST_DRAIN;
        ST_DRAIN: if (drain_done) state_reg <= ST_CLEAR;
        ST_CLEAR: begin
          if (clr_cnt_reg == 9'd511) begin
            clr_cnt_reg <= '0;
            state_reg   <= ST_READY;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 9'd1;
          end
        end
        default: state_reg <= ST_READY;
      endcase
    end
  end

  for (genvar gi = 0; gi < NR_BANKS; gi++) begin : g_bank
    logic hit;
    assign hit = accept & in_range & (req_bank == BW'(gi));

    ram512x32 u_ram (
      .clk_i   (clk_i),
      .cen_i   (~(hit | clearing)),
      .wen_i   (clearing | (hit & wb_we_i)),
      .be_i    (clearing ? 4'hF : wb_sel_i),
      .addr_i  (clearing ? clr_cnt_reg : wb_adr_i[8:0]),
      .wdata_i (clearing ? 32'h0 : wb_dat_i),
      .rdata_o (bank_rdata[gi])
    );
  end

  // Mux by the bank captured with the request, not the address currently on the bus.
  assign sel_rdata = bank_rdata[bank1_reg];

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic        v2_reg, e2_reg;
      logic [31:0] dat2_reg;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          v2_reg   <= 1'b0;
          e2_reg   <= 1'b0;
          dat2_reg <= '0;
        end else begin
          v2_reg   <= v1_reg & wb_cyc_i;
          e2_reg   <= e1_reg;
          dat2_reg <= (v1_reg & rd1_reg) ? sel_rdata : 32'h0;
        end
      end
      assign out_v   = v2_reg;
      assign out_e   = e2_reg;
      assign out_dat = dat2_reg;
    end else begin : g_onoreg
      assign out_v   = v1_reg;
      assign out_e   = e1_reg;
      assign out_dat = rd1_reg ? sel_rdata : 32'h0;
    end
  endgenerate

  // A dropped cycle suppresses whatever response is presented in that same cycle.
  assign wb_ack_o = out_v & ~out_e & wb_cyc_i & ~rst_i;
  assign wb_err_o = out_v &  out_e & wb_cyc_i & ~rst_i;
  assign wb_dat_o = wb_ack_o ? out_dat : 32'h0;
endmodule

// File: tb/tb_wb_ram_pipe.sv
// Scoreboard bench for wb_ram_pipe: u0 = 1024 words, latency 1, clear on reset;
// u1 = 600 words, latency 2, no clear on reset.
module tb_wb_ram_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        cyc [2], stb [2], we [2], clr [2];
  logic [3:0]  sel [2];
  logic [9:0]  adr [2];
  logic [31:0] wdat [2], rdat [2];
  logic        ack [2], err [2], stall [2], busy [2];

  always #5 clk = ~clk;

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  int ncmp = 0;
  int nfail = 0;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] dat;
    logic        chk;
  } exp_t;

  exp_t        q0[$], q1[$];
  logic [31:0] mdl [2][1024];

  wb_ram_pipe #(.DEPTH(1024), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_sel_i(sel[0]), .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]),
    .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_stall_o(stall[0]), .clear_i(clr[0]),
    .busy_o(busy[0]));

  wb_ram_pipe #(.DEPTH(600), .OUT_REG(1), .CLEAR_ON_RESET(0)) u1 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_sel_i(sel[1]), .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]),
    .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_stall_o(stall[1]), .clear_i(clr[1]),
    .busy_o(busy[1]));

  function automatic int dep(input int d);
    return (d == 0) ? 1024 : 600;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL u%0d %s: observed %h expected %h", d, tag, obs, expv);
    end
  endtask

  task automatic qpush(input int d, input exp_t e);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic qpop(input int d, output exp_t e);
    if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
  endtask

  task automatic mon(input int d);
    exp_t e;
    if (ack[d] | err[d]) begin
      chk(d, "ack_err_excl", {31'b0, ack[d] & err[d]}, 32'h0);
      if (qsize(d) == 0) begin
        chk(d, "unexpected_rsp", 32'h1, 32'h0);
      end else begin
        qpop(d, e);
        chk(d, "rsp_cycle", 32'(cnt), 32'(e.due));
        chk(d, "rsp_err", {31'b0, err[d]}, {31'b0, e.err});
        if (e.chk) chk(d, "rsp_dat", rdat[d], e.dat);
        $display("u%0d rsp cycle=%0d ack=%0b err=%0b dat=%h", d, cnt, ack[d], err[d], rdat[d]);
      end
    end else begin
      chk(d, "dat_idle", rdat[d], 32'h0);
      if (qsize(d) > 0) begin
        e = (d == 0) ? q0[0] : q1[0];
        if (e.due <= cnt) begin
          qpop(d, e);
          chk(d, "rsp_missing", 32'h0, 32'h1);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Called just after a rising edge; presents one request for one cycle.
  task automatic req(input int d, input logic w, input int a, input logic [31:0] dv,
                     input logic [3:0] s, input logic chkd, input logic [31:0] expd);
    exp_t e;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
    adr[d] = 10'(a); wdat[d] = dv; sel[d] = s;
    @(negedge clk);
    chk(d, "stall_on_req", {31'b0, stall[d]}, 32'h0);
    e.due = cnt + lat(d);
    e.err = (a >= dep(d));
    e.dat = e.err ? 32'h0 : expd;
    e.chk = chkd | e.err;
    qpush(d, e);
    if (w && !e.err) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[d][a][8*b +: 8] = dv[8*b +: 8];
    end
    $display("u%0d req cycle=%0d we=%0b adr=%0d dat=%h sel=%h", d, cnt, w, a, dv, s);
    @(posedge clk); #1;
    stb[d] = 1'b0; we[d] = 1'b0;
  endtask

  task automatic wr(input int d, input int a, input logic [31:0] v, input logic [3:0] s);
    req(d, 1'b1, a, v, s, 1'b0, 32'h0);
  endtask

  task automatic rd(input int d, input int a);
    req(d, 1'b0, a, 32'h0, 4'hF, 1'b1, (a < 1024) ? mdl[d][a] : 32'h0);
  endtask

  task automatic rdx(input int d, input int a, input logic [31:0] expv);
    req(d, 1'b0, a, 32'h0, 4'hF, 1'b1, expv);
  endtask

  task automatic flush(input int d);
    stb[d] = 1'b0;
    for (int i = 0; i < 20 && qsize(d) > 0; i++) @(posedge clk);
    chk(d, "flush_pending", 32'(qsize(d)), 32'h0);
    #1;
    cyc[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic count_busy(input int d, output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy[d]) break;
      n++;
    end
    chk(d, "stall_after_busy", {31'b0, stall[d]}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic abort_rd(input int d, input int a);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; adr[d] = 10'(a); sel[d] = 4'hF;
    @(posedge clk); #1;
    cyc[d] = 1'b0; stb[d] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(d, "abort_no_ack", {31'b0, ack[d]}, 32'h0);
    end
    $display("u%0d abort read adr=%0d", d, a);
    @(posedge clk); #1;
  endtask

  task automatic rst_checks();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_ack", {31'b0, ack[d]}, 32'h0);
      chk(d, "rst_err", {31'b0, err[d]}, 32'h0);
      chk(d, "rst_dat", rdat[d], 32'h0);
      chk(d, "rst_stall", {31'b0, stall[d]}, 32'h1);
      chk(d, "rst_busy", {31'b0, busy[d]}, (d == 0) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    exp_t e;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 0; stb[d] = 0; we[d] = 0; clr[d] = 0; sel[d] = 0; adr[d] = 0; wdat[d] = 0;
      for (int i = 0; i < 1024; i++) mdl[d][i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_checks();
    @(posedge clk); #1;
    rst = 1'b0;

    // Clear after reset: exactly 512 busy cycles; u1 ready at once
    count_busy(0, n);
    chk(0, "reset_clear_len", 32'(n), 32'd512);
    chk(1, "noclr_busy", {31'b0, busy[1]}, 32'h0);

    // Garbage, then reset interrupted at clear cycle ~200, then full clear
    wr(0, 0, $urandom, 4'hF);
    wr(0, 511, $urandom, 4'hF);
    wr(0, 512, $urandom, 4'hF);
    wr(0, 1023, $urandom, 4'hF);
    rd(0, 0); rd(0, 511); rd(0, 512); rd(0, 1023);
    flush(0);
    rst = 1'b1;
    rst_checks();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    rst = 1'b1;
    rst_checks();
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(0, n);
    chk(0, "restart_clear_len", 32'(n), 32'd512);
    for (int i = 0; i < 1024; i++) mdl[0][i] = 32'h0;
    rdx(0, 0, 32'h0); rdx(0, 511, 32'h0); rdx(0, 512, 32'h0); rdx(0, 1023, 32'h0);
    flush(0);

    // Bank switching, back to back
    wr(0, 511, 32'd1, 4'hF); wr(0, 512, 32'd2, 4'hF);
    wr(0, 0, 32'd3, 4'hF);   wr(0, 1023, 32'd4, 4'hF);
    rdx(0, 511, 32'd1); rdx(0, 512, 32'd2); rdx(0, 0, 32'd3); rdx(0, 1023, 32'd4);
    flush(0);

    // Byte lanes with read right after write, latency 1
    wr(0, 5, 32'hDEADBEEF, 4'hF);
    wr(0, 5, 32'h00AA0000, 4'b0100);
    rdx(0, 5, 32'hDEAABEEF);
    flush(0);
    abort_rd(0, 5);

    // u1: byte lanes at latency 2, then range error
    wr(1, 5, 32'hDEADBEEF, 4'hF);
    wr(1, 5, 32'h00AA0000, 4'b0100);
    rdx(1, 5, 32'hDEAABEEF);
    wr(1, 188, 32'hA1A1A1A1, 4'hF);
    wr(1, 599, 32'hB2B2B2B2, 4'hF);
    wr(1, 700, 32'hCCCCCCCC, 4'hF);
    rd(1, 700);
    rdx(1, 599, 32'hB2B2B2B2);
    rdx(1, 188, 32'hA1A1A1A1);
    flush(1);
    abort_rd(1, 599);

    // Runtime clear pulsed with an accepted read
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 10'd599; sel[1] = 4'hF; clr[1] = 1'b1;
    @(negedge clk);
    chk(1, "stall_on_clear_req", {31'b0, stall[1]}, 32'h0);
    e.due = cnt + 2; e.err = 1'b0; e.dat = 32'hB2B2B2B2; e.chk = 1'b1;
    qpush(1, e);
    $display("u1 req cycle=%0d clear with read adr=599", cnt);
    @(posedge clk); #1;
    stb[1] = 1'b0; clr[1] = 1'b0;
    @(negedge clk);
    chk(1, "stall_in_drain", {31'b0, stall[1]}, 32'h1);
    chk(1, "busy_in_drain", {31'b0, busy[1]}, 32'h1);
    count_busy(1, n);
    n = n + 1;
    chk(1, "rt_clear_len_ok", {31'b0, (n >= 512 && n <= 514)}, 32'h1);
    chk(1, "rt_clear_rsp_done", 32'(qsize(1)), 32'h0);
    for (int i = 0; i < 1024; i++) mdl[1][i] = 32'h0;
    rdx(1, 0, 32'h0); rdx(1, 5, 32'h0); rdx(1, 188, 32'h0); rdx(1, 599, 32'h0);
    flush(1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
